secure_voting_machine_core: RTL and testbench

//  Three-candidate electronic ballot controller. An administrator unlocks voting with a
//  4-bit password. Each 4-bit voter ID may cast exactly one vote for A, B or C.

---
 rtl/secure_voting_machine_core.sv | 131 +++++++++++++
 tb/tb_secure_voting_machine_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/secure_voting_machine_core.sv
// Three-candidate ballot controller: password unlock, one vote per 4-bit voter ID,
// saturating per-candidate counters and a registered winner once the poll closes.
module secure_voting_machine_core #(
  parameter logic [3:0] PASSWORD  = 4'b1010,
  parameter int         COUNT_W   = 8,
  parameter int         MAX_FAILS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         admin_password,
  input  logic               enable_admin,
  input  logic               result_mode,
  input  logic [3:0]         voter_id,
  input  logic               vote_a,
  input  logic               vote_b,
  input  logic               vote_c,
  output logic [COUNT_W-1:0] count_a,
  output logic [COUNT_W-1:0] count_b,
  output logic [COUNT_W-1:0] count_c,
  output logic [1:0]         winner,
  output logic               voting_enabled,
  output logic               busy
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_LOCKED, S_READY, S_RECORD, S_RESULT, S_LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [15:0]        voted_q, voted_d;
  logic [2:0]         vote_q;
  logic [COUNT_W-1:0] count_a_q, count_a_d, count_b_q, count_b_d, count_c_q, count_c_d;
  logic [1:0]         winner_q, winner_d;
  logic               voting_enabled_q, voting_enabled_d;
  logic               busy_q, busy_d;
  logic [2:0]         vote_edge;
  logic               single_edge;

  assign vote_edge   = {vote_a, vote_b, vote_c} & ~vote_q;
  assign single_edge = (vote_edge == 3'b100) || (vote_edge == 3'b010) || (vote_edge == 3'b001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_LOCKED;
      fail_cnt_q       <= '0;
      voted_q          <= '0;
      vote_q           <= '0;
      count_a_q        <= '0;
      count_b_q        <= '0;
      count_c_q        <= '0;
      winner_q         <= 2'b00;
      voting_enabled_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      fail_cnt_q       <= fail_cnt_d;
      voted_q          <= voted_d;
      vote_q           <= {vote_a, vote_b, vote_c};
      count_a_q        <= count_a_d;
      count_b_q        <= count_b_d;
      count_c_q        <= count_c_d;
      winner_q         <= winner_d;
      voting_enabled_q <= voting_enabled_d;
      busy_q           <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    voted_d    = voted_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    count_c_d  = count_c_q;
    case (state_q)
      S_LOCKED: begin
        if (result_mode) begin
          state_d = S_RESULT;
        end else if (enable_admin) begin
          if (admin_password == PASSWORD) begin
            state_d = S_READY;
          end else begin
            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
            if (fail_cnt_d == FAIL_W'(MAX_FAILS)) state_d = S_LOCKOUT;
          end
        end
      end
      S_READY: begin
        if (result_mode) begin
          state_d = S_RESULT;
        end else if (single_edge && !voted_q[voter_id]) begin
          // A vote at saturation is still consumed: the voter is marked either way.
          voted_d[voter_id] = 1'b1;
          state_d           = S_RECORD;
          if (vote_edge[2] && count_a_q != CNT_MAX) count_a_d = count_a_q + CNT_ONE;
          if (vote_edge[1] && count_b_q != CNT_MAX) count_b_d = count_b_q + CNT_ONE;
          if (vote_edge[0] && count_c_q != CNT_MAX) count_c_d = count_c_q + CNT_ONE;
        end
      end
      S_RECORD:  state_d = result_mode ? S_RESULT : S_READY;
      S_LOCKOUT: if (result_mode) state_d = S_RESULT;
      S_RESULT:  state_d = S_RESULT;
      default:   state_d = S_LOCKED;
    endcase
  end

  // Outputs are registered from the next state, so they appear one clock after the cause.
  always_comb begin
    voting_enabled_d = (state_d == S_READY) || (state_d == S_RECORD);
    busy_d           = (state_d == S_RECORD);
    winner_d         = 2'b00;
    if (state_d == S_RESULT) begin
      if (count_a_q > count_b_q && count_a_q > count_c_q)      winner_d = 2'b01;
      else if (count_b_q > count_a_q && count_b_q > count_c_q) winner_d = 2'b10;
      else if (count_c_q > count_a_q && count_c_q > count_b_q) winner_d = 2'b11;
    end
  end

  assign count_a        = count_a_q;
  assign count_b        = count_b_q;
  assign count_c        = count_c_q;
  assign winner         = winner_q;
  assign voting_enabled = voting_enabled_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_secure_voting_machine_core.sv
// Directed bench for secure_voting_machine_core: unlock, voting, ties, lockout and
// simultaneous-edge handling, each compared against hand-computed values.
module tb_secure_voting_machine_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] admin_password = 4'b0000;
  logic       enable_admin = 1'b0;
  logic       result_mode = 1'b0;
  logic [3:0] voter_id = 4'd0;
  logic       vote_a = 1'b0, vote_b = 1'b0, vote_c = 1'b0;
  logic [7:0] count_a, count_b, count_c;
  logic [1:0] winner;
  logic       voting_enabled, busy;

  int checks = 0;
  int failures = 0;
  logic busy_seen;

  secure_voting_machine_core dut (
    .clk(clk), .reset(reset), .admin_password(admin_password),
    .enable_admin(enable_admin), .result_mode(result_mode), .voter_id(voter_id),
    .vote_a(vote_a), .vote_b(vote_b), .vote_c(vote_c),
    .count_a(count_a), .count_b(count_b), .count_c(count_c),
    .winner(winner), .voting_enabled(voting_enabled), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {enable_admin, result_mode, vote_a, vote_b, vote_c} = '0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic unlock();
    admin_password = 4'b1010;
    enable_admin   = 1'b1;
    step();
    enable_admin   = 1'b0;
  endtask

  // Drive the vote lines for one clock, record busy, then drop them for one clock.
  task automatic cast(input logic [3:0] id, input logic [2:0] abc);
    voter_id = id;
    {vote_a, vote_b, vote_c} = abc;
    step();
    busy_seen = busy;
    {vote_a, vote_b, vote_c} = 3'b000;
    step();
  endtask

  task automatic check_counts(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c);
    check_eq({tag, "_a"}, count_a, a);
    check_eq({tag, "_b"}, count_b, b);
    check_eq({tag, "_c"}, count_c, c);
  endtask

  initial begin
    #2;
    check_counts("rst", 0, 0, 0);
    check_eq("rst_winner", winner, 0);
    check_eq("rst_ve", voting_enabled, 0);
    check_eq("rst_busy", busy, 0);
    step();
    reset = 1'b1;
    step();

    // Unlock and first vote, then a repeat vote from the same ID
    unlock();
    check_eq("t1_ve", voting_enabled, 1);
    check_counts("t1", 0, 0, 0);
    cast(4'd1, 3'b100);
    check_eq("t2_busy_pulse", busy_seen, 1);
    check_eq("t2_busy_after", busy, 0);
    check_counts("t2", 1, 0, 0);
    cast(4'd1, 3'b010);
    check_eq("t2_dup_busy", busy_seen, 0);
    check_counts("t2_dup", 1, 0, 0);

    // Three-way tie
    cast(4'd2, 3'b010);
    cast(4'd3, 3'b001);
    result_mode = 1'b1;
    step();
    check_counts("t3", 1, 1, 1);
    check_eq("t3_winner_tie", winner, 2'b00);
    check_eq("t3_ve", voting_enabled, 0);

    // Clear winner for A; votes after close are ignored
    do_reset();
    check_eq("t4_winner_reset", winner, 2'b00);
    unlock();
    cast(4'd4, 3'b100);
    cast(4'd5, 3'b100);
    cast(4'd6, 3'b010);
    check_eq("t4_winner_open", winner, 2'b00);
    result_mode = 1'b1;
    step();
    check_eq("t4_winner_a", winner, 2'b01);
    cast(4'd7, 3'b001);
    cast(4'd8, 3'b100);
    check_counts("t4_post", 2, 1, 0);
    check_eq("t4_winner_held", winner, 2'b01);

    // Wrong password three times -> lockout
    do_reset();
    admin_password = 4'b0000;
    enable_admin   = 1'b1;
    step();
    step();
    step();
    admin_password = 4'b1010;
    step();
    step();
    enable_admin = 1'b0;
    check_eq("t5_lockout_ve", voting_enabled, 0);
    cast(4'd0, 3'b100);
    check_counts("t5", 0, 0, 0);
    result_mode = 1'b1;
    step();
    check_eq("t5_result_winner", winner, 2'b00);

    // Two wrong attempts do not lock out
    do_reset();
    admin_password = 4'b0001;
    enable_admin   = 1'b1;
    step();
    step();
    admin_password = 4'b1010;
    step();
    enable_admin = 1'b0;
    check_eq("fail2_then_ok_ve", voting_enabled, 1);

    // Simultaneous edges ignored and voter left unmarked
    do_reset();
    unlock();
    cast(4'd8, 3'b110);
    check_eq("t6_multi_busy", busy_seen, 0);
    check_counts("t6_multi", 0, 0, 0);
    cast(4'd8, 3'b010);
    check_eq("t6_retry_busy", busy_seen, 1);
    check_counts("t6_retry", 0, 1, 0);

    // result_mode beats a same-cycle vote
    do_reset();
    unlock();
    voter_id = 4'd9;
    vote_c = 1'b1;
    result_mode = 1'b1;
    step();
    check_eq("prio_busy", busy, 0);
    check_eq("prio_ve", voting_enabled, 0);
    check_counts("prio", 0, 0, 0);

    // result_mode beats enable_admin in LOCKED
    do_reset();
    admin_password = 4'b1010;
    enable_admin = 1'b1;
    result_mode = 1'b1;
    step();
    enable_admin = 1'b0;
    step();
    check_eq("locked_prio_ve", voting_enabled, 0);

    // Asynchronous reset while a vote is being recorded
    do_reset();
    unlock();
    voter_id = 4'd10;
    vote_b = 1'b1;
    step();
    check_eq("mid_busy", busy, 1);
    check_eq("mid_count_b", count_b, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_count_b", count_b, 0);
    check_eq("mid_rst_ve", voting_enabled, 0);
    vote_b = 1'b0;
    step();
    reset = 1'b1;
    step();
    unlock();
    cast(4'd10, 3'b010);
    check_eq("mid_rst_revote", count_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
